// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit with valid/ready flow control.
// Each stage resolves one WIDTH/STAGES slice using the carry registered by the stage before.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             O_VALID,
    input  logic             O_READY
);

    localparam int SLICE = WIDTH / STAGES;

    if (STAGES < 1 || WIDTH < 1 || (WIDTH % STAGES) != 0) begin : gBadParams
        $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
    end

    logic             stall;
    logic             advance;
    logic [WIDTH-1:0] bEff;
    logic             cEff;

    // Stage registers: operands travel alongside the partial sum.
    logic [STAGES-1:0]            vldQ;
    logic [STAGES-1:0]            cyQ;
    logic [STAGES-1:0][WIDTH-1:0] aQ;
    logic [STAGES-1:0][WIDTH-1:0] bQ;
    logic [STAGES-1:0][WIDTH-1:0] sQ;
    logic                         ovfQ;

    logic [STAGES-1:0]            vldD;
    logic [STAGES-1:0]            cyD;
    logic [STAGES-1:0][WIDTH-1:0] aD;
    logic [STAGES-1:0][WIDTH-1:0] bD;
    logic [STAGES-1:0][WIDTH-1:0] sD;
    logic                         ovfD;

    // Index k of a chain is the input of stage k; index 0 is the port side.
    logic [STAGES:0]            vChain;
    logic [STAGES:0]            cChain;
    logic [STAGES:0][WIDTH-1:0] aChain;
    logic [STAGES:0][WIDTH-1:0] bChain;
    logic [STAGES:0][WIDTH-1:0] sChain;
    logic                       unusedBits;

    logic [SLICE:0] part;

    // Subtract is A + ~B + ~CIN, giving A - B - CIN.
    assign bEff = SUB ? ~B : B;
    assign cEff = SUB ? ~CIN : CIN;

    assign vChain = {vldQ, I_VALID};
    assign cChain = {cyQ, cEff};
    assign aChain = {aQ, A};
    assign bChain = {bQ, bEff};
    assign sChain = {sQ, {WIDTH{1'b0}}};

    // The last stage's chain entries are the outputs, read directly below.
    assign unusedBits = ^{vChain[STAGES], cChain[STAGES], aChain[STAGES],
                          bChain[STAGES], sChain[STAGES]};

    assign stall   = vldQ[STAGES-1] & ~O_READY;
    assign advance = ~stall;
    assign I_READY = advance;

    assign O_VALID = vldQ[STAGES-1];
    assign SUM     = sQ[STAGES-1];
    assign COUT    = cyQ[STAGES-1];
    assign OVF     = ovfQ;

    // Per-stage slice add; overflow is resolved once the top slice is known.
    always_comb begin
        vldD = vChain[STAGES-1:0];
        aD   = aChain[STAGES-1:0];
        bD   = bChain[STAGES-1:0];
        sD   = sChain[STAGES-1:0];
        cyD  = '0;
        part = '0;
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, aChain[k][k*SLICE +: SLICE]}
                 + {1'b0, bChain[k][k*SLICE +: SLICE]}
                 + {{SLICE{1'b0}}, cChain[k]};
            sD[k][k*SLICE +: SLICE] = part[SLICE-1:0];
            cyD[k]                  = part[SLICE];
        end
        ovfD = (aChain[STAGES-1][WIDTH-1] == bChain[STAGES-1][WIDTH-1])
            && (sD[STAGES-1][WIDTH-1] != aChain[STAGES-1][WIDTH-1]);
    end

    // Whole pipeline moves together, bubbles included, unless the output stalls.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            vldQ <= '0;
            cyQ  <= '0;
            aQ   <= '0;
            bQ   <= '0;
            sQ   <= '0;
            ovfQ <= 1'b0;
        end else if (advance) begin
            vldQ <= vldD;
            cyQ  <= cyD;
            aQ   <= aD;
            bQ   <= bD;
            sQ   <= sD;
            ovfQ <= ovfD;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4).
// Results are scoreboarded against an integer-arithmetic reference.
module tb_pipelined_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             CLK = 1'b0;
    logic             ASYNCRESET;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             SUB;
    logic             I_VALID;
    logic             I_READY;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             OVF;
    logic             O_VALID;
    logic             O_READY;

    int checks = 0;
    int errors = 0;
    int nStall = 0;
    int nOut   = 0;

    logic [17:0] expQ[$];

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .CLK(CLK),
        .ASYNCRESET(ASYNCRESET),
        .A(A),
        .B(B),
        .CIN(CIN),
        .SUB(SUB),
        .I_VALID(I_VALID),
        .I_READY(I_READY),
        .SUM(SUM),
        .COUT(COUT),
        .OVF(OVF),
        .O_VALID(O_VALID),
        .O_READY(O_READY)
    );

    always #5 CLK = ~CLK;

    // Returns {ovf, cout, sum} from plain signed/unsigned integer arithmetic.
    function automatic logic [17:0] refModel(input logic [15:0] a, input logic [15:0] b,
                                             input logic ci, input logic sub);
        int ua, ub, sa, sb, c, u, s;
        logic [15:0] sm;
        logic co, ov;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c  = ci ? 1 : 0;
        if (!sub) begin
            u  = ua + ub + c;
            s  = sa + sb + c;
            co = (u > 65535);
        end else begin
            u  = ua - ub - c;
            s  = sa - sb - c;
            co = (u >= 0);
        end
        sm = u[15:0];
        ov = (s > 32767) || (s < -32768);
        return {ov, co, sm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes seen before the edge, verify afterwards.
    task automatic tick(output bit acc);
        bit con, stl;
        logic [17:0] held;
        logic [17:0] exp;
        #2;
        acc  = (I_VALID === 1'b1) && (I_READY === 1'b1);
        con  = (O_VALID === 1'b1) && (O_READY === 1'b1);
        stl  = (O_VALID === 1'b1) && (O_READY === 1'b0);
        held = {OVF, COUT, SUM};
        check("i_ready", 32'(I_READY), 32'(!stl));
        if (acc) expQ.push_back(refModel(A, B, CIN, SUB));
        if (con) begin
            check("result_expected", 32'(expQ.size() != 0), 32'(1));
            if (expQ.size() != 0) begin
                exp = expQ.pop_front();
                check("result", 32'({OVF, COUT, SUM}), 32'(exp));
                nOut++;
            end
        end
        @(posedge CLK);
        #1;
        if (stl) begin
            nStall++;
            check("stall_hold", 32'({O_VALID, OVF, COUT, SUM}), 32'({1'b1, held}));
        end
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic sub, input logic [15:0] eSum,
                            input logic eCout, input logic eOvf);
        bit acc;
        int n;
        A = a; B = b; CIN = ci; SUB = sub;
        I_VALID = 1'b1;
        O_READY = 1'b1;
        tick(acc);
        I_VALID = 1'b0;
        check($sformatf("%s_accept", tag), 32'(acc), 32'(1));
        n = 1;
        while (O_VALID !== 1'b1 && n < 20) begin
            tick(acc);
            n++;
        end
        check($sformatf("%s_latency", tag), 32'(n), 32'(STAGES));
        check($sformatf("%s_value", tag), 32'({OVF, COUT, SUM}), 32'({eOvf, eCout, eSum}));
        tick(acc);
    endtask

    task automatic drain(input string tag);
        bit acc;
        I_VALID = 1'b0;
        O_READY = 1'b1;
        for (int n = 0; n < 40 && expQ.size() != 0; n++) tick(acc);
        check(tag, 32'(expQ.size()), 32'(0));
    endtask

    initial begin
        bit acc;
        int sent, stall0, out0, stale;

        ASYNCRESET = 1'b1;
        A = '0; B = '0; CIN = 1'b0; SUB = 1'b0;
        I_VALID = 1'b0;
        O_READY = 1'b1;
        #1;
        check("reset_outputs", 32'({O_VALID, OVF, COUT, SUM}), 32'(0));
        check("reset_iready", 32'(I_READY), 32'(1));
        tick(acc);
        tick(acc);
        ASYNCRESET = 1'b0;
        tick(acc);
        check("post_reset_idle", 32'(O_VALID), 32'(0));

        directed("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed("add_cin",    16'h0010, 16'h0020, 1'b1, 1'b0, 16'h0031, 1'b0, 1'b0);
        directed("sub_cin",    16'h0010, 16'h0005, 1'b1, 1'b1, 16'h000A, 1'b1, 1'b0);
        directed("sub_cin_ov", 16'h8000, 16'h7FFF, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1);

        // Eight back-to-back transactions with a three-cycle output stall.
        sent   = 0;
        stall0 = nStall;
        out0   = nOut;
        for (int c = 0; c < 60 && (sent < 8 || expQ.size() != 0); c++) begin
            A       = 16'($urandom);
            B       = 16'($urandom);
            CIN     = 1'($urandom);
            SUB     = 1'($urandom);
            I_VALID = (sent < 8);
            O_READY = !(c >= 6 && c <= 8);
            tick(acc);
            if (acc) sent++;
        end
        check("burst_sent", 32'(sent), 32'(8));
        check("burst_results", 32'(nOut - out0), 32'(8));
        check("burst_stall_cycles", 32'(nStall - stall0), 32'(3));
        drain("burst_drain");

        // Reset with three transactions in flight, one of them on the output.
        O_READY = 1'b1;
        for (int j = 0; j < 3; j++) begin
            A       = 16'($urandom);
            B       = 16'($urandom);
            CIN     = 1'($urandom);
            SUB     = 1'($urandom);
            I_VALID = 1'b1;
            tick(acc);
            check("inflight_accept", 32'(acc), 32'(1));
        end
        I_VALID = 1'b0;
        O_READY = 1'b0;
        tick(acc);
        check("prereset_valid", 32'(O_VALID), 32'(1));
        #1;
        ASYNCRESET = 1'b1;
        #1;
        check("async_reset_outputs", 32'({O_VALID, OVF, COUT, SUM}), 32'(0));
        check("async_reset_iready", 32'(I_READY), 32'(1));
        expQ.delete();
        tick(acc);
        ASYNCRESET = 1'b0;
        O_READY = 1'b1;
        stale = 0;
        for (int j = 0; j < 8; j++) begin
            tick(acc);
            if (O_VALID !== 1'b0) stale++;
        end
        check("no_stale_results", 32'(stale), 32'(0));
        directed("after_reset", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Random traffic with random backpressure.
        for (int c = 0; c < 300; c++) begin
            A       = 16'($urandom);
            B       = 16'($urandom);
            CIN     = 1'($urandom);
            SUB     = 1'($urandom);
            I_VALID = ($urandom_range(0, 3) != 0);
            O_READY = ($urandom_range(0, 3) != 0);
            tick(acc);
        end
        drain("random_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
